axis_rr_packet_arbiter: RTL and testbench

- Control and data stage directly upstream of the stream multiplexer.
- Accepts two AXI-Stream sources and arbitrates between them round-robin at packet granularity, locking the grant from the first beat through the beat with tlast.
- Drives the mux select code and presents the granted stream on one registered AXI-Stream master port with full-throughput backpressure.

---
 rtl/axis_pkg.sv | 14 +
 rtl/axis_rr_packet_arbiter_if.sv | 16 +
 rtl/axis_out_reg.sv | 36 +++
 rtl/axis_rr_packet_arbiter.sv | 92 +++++++++
 tb/tb_axis_rr_packet_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the round-robin packet arbiter and the stream mux it feeds.
// Select codes are shared with the downstream mux.
// The arbiter FSM has two states.
package axis_pkg;

  localparam logic [1:0] SEL_S0 = 2'b00;
  localparam logic [1:0] SEL_S1 = 2'b01;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

endpackage

// File: rtl/axis_rr_packet_arbiter_if.sv
// AXI-Stream channel bundle (tdata/tvalid/tlast/tready).
// master drives data/valid/last and samples ready.
// slave samples data/valid/last and drives ready.
interface axis_rr_packet_arbiter_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream register slice: in_* loads out_*, out_* holds until taken.
// Latency: 1 cycle from accepted input beat to out_tvalid; 1 beat/cycle when out_tready stays high.
// Backpressure: in_tready = !out_tvalid || out_tready (combinational, no skid entry).
module axis_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  input  logic                  in_tlast,
  output logic                  in_tready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  output logic                  out_tlast,
  input  logic                  out_tready
);

  // Register can take a new beat when empty or when its current beat leaves this cycle.
  assign in_tready = !out_tvalid || out_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
    end else if (in_tvalid && in_tready) begin
      out_tvalid <= 1'b1;
      out_tdata  <= in_tdata;
      out_tlast  <= in_tlast;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Two-source AXI-Stream arbiter, round-robin per packet, grant locked first beat through tlast.
// Latency: grant 1 cycle after tvalid in IDLE, first beat on m_* 1 cycle after that; 1 dead cycle between packets.
// Backpressure: granted tready follows m_tready combinationally; non-granted source always sees tready=0.
// Ports: clk, rst_n (sync, active-low), s0/s1 slave streams, m master stream, select (grant code), busy (in GRANT).
module axis_rr_packet_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_STREAMS = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  axis_rr_packet_arbiter_if.slave       s0,
  axis_rr_packet_arbiter_if.slave       s1,
  axis_rr_packet_arbiter_if.master      m,
  output logic [NUM_STREAMS-1:0]        select,
  output logic                          busy
);

  import axis_pkg::*;

  generate
    if (NUM_STREAMS != 2) begin : g_bad_num_streams
      $error("axis_rr_packet_arbiter supports NUM_STREAMS == 2 only");
    end
  endgenerate

  state_t                state;
  logic                  ptr;        // source holding priority on a tie: 0 = s0, 1 = s1
  logic                  gnt;        // granted source index, taken from the select code
  logic [DATA_WIDTH-1:0] gnt_tdata;
  logic                  gnt_tvalid;
  logic                  gnt_tlast;
  logic                  gnt_tready;
  logic                  slice_rdy;
  logic                  accept;

  assign gnt = select[0];

  assign gnt_tdata  = gnt ? s1.tdata : s0.tdata;
  assign gnt_tlast  = gnt ? s1.tlast : s0.tlast;
  // Valid into the slice is gated by GRANT so nothing is loaded during the IDLE gap.
  assign gnt_tvalid = (state == ST_GRANT) && (gnt ? s1.tvalid : s0.tvalid);
  assign gnt_tready = (state == ST_GRANT) && slice_rdy;
  assign accept     = gnt_tvalid && gnt_tready;

  assign s0.tready = gnt_tready && !gnt;
  assign s1.tready = gnt_tready && gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ptr    <= 1'b0;
      select <= SEL_S0;
      busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s0.tvalid || s1.tvalid) begin
            state <= ST_GRANT;
            busy  <= 1'b1;
            // s1 wins when it is the only requester, or on a tie when it holds priority.
            if (s1.tvalid && (!s0.tvalid || ptr)) select <= SEL_S1;
            else                                  select <= SEL_S0;
          end
        end
        ST_GRANT: begin
          if (accept && gnt_tlast) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            ptr   <= !gnt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tdata   (gnt_tdata),
    .in_tvalid  (gnt_tvalid),
    .in_tlast   (gnt_tlast),
    .in_tready  (slice_rdy),
    .out_tdata  (m.tdata),
    .out_tvalid (m.tvalid),
    .out_tlast  (m.tlast),
    .out_tready (m.tready)
  );

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed bench: packet-level round-robin model feeding an expected-beat queue,
// checked on every output handshake, plus cycle-exact literal expectations.
// Inputs change 1 time unit after posedge; DUT outputs are sampled on negedge.
module tb_axis_rr_packet_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] select;
  logic       busy;

  always #5 clk = ~clk;

  axis_rr_packet_arbiter_if #(.DATA_WIDTH(8)) s0_if ();
  axis_rr_packet_arbiter_if #(.DATA_WIDTH(8)) s1_if ();
  axis_rr_packet_arbiter_if #(.DATA_WIDTH(8)) m_if ();

  axis_rr_packet_arbiter #(
    .DATA_WIDTH  (8),
    .NUM_STREAMS (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s0     (s0_if),
    .s1     (s1_if),
    .m      (m_if),
    .select (select),
    .busy   (busy)
  );

  int errors = 0;
  int checks = 0;

  // Model state: expected output beats {tlast, tdata} and the priority source.
  logic [8:0] exp_q[$];
  bit         mdl_ptr = 1'b0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- packet-level model ----------------
  task automatic mdl_push(input logic [7:0] d[$]);
    for (int i = 0; i < d.size(); i++)
      exp_q.push_back({(i == d.size() - 1), d[i]});
  endtask

  // A lone packet is served and priority moves to the other source.
  task automatic mdl_solo(input int src, input logic [7:0] d[$]);
    mdl_push(d);
    mdl_ptr = (src == 0);
  endtask

  // Both sources waiting in the same idle cycle: priority holder first, then the other.
  task automatic mdl_both(input logic [7:0] d0[$], input logic [7:0] d1[$]);
    if (!mdl_ptr) begin
      mdl_push(d0);
      mdl_push(d1);
    end else begin
      mdl_push(d1);
      mdl_push(d0);
    end
  endtask

  // ---------------- compare process ----------------
  logic       hold_prev = 1'b0;
  logic [8:0] hold_val  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev <= 1'b0;
    end else begin
      check("ready_consistency",
            32'(!(s0_if.tready && s1_if.tready) &&
                (!(s0_if.tready || s1_if.tready) || busy) &&
                (select <= 2'b01)), 32'd1);
      if (hold_prev)
        check("stall_hold", 32'({m_if.tvalid, m_if.tlast, m_if.tdata}), 32'({1'b1, hold_val}));
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got 0x%0h required none at %0t",
                   {m_if.tlast, m_if.tdata}, $time);
        end else begin
          check("beat", 32'({m_if.tlast, m_if.tdata}), 32'(exp_q.pop_front()));
        end
      end
      hold_prev <= m_if.tvalid && !m_if.tready;
      hold_val  <= {m_if.tlast, m_if.tdata};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int src, input logic [7:0] d, input logic l);
    bit done = 1'b0;
    bit hs;
    int n = 0;
    if (src == 0) begin
      s0_if.tvalid = 1'b1; s0_if.tdata = d; s0_if.tlast = l;
    end else begin
      s1_if.tvalid = 1'b1; s1_if.tdata = d; s1_if.tlast = l;
    end
    while (!done) begin
      @(negedge clk);
      hs = (src == 0) ? s0_if.tready : s1_if.tready;
      @(posedge clk);
      #1;
      if (hs) done = 1'b1;
      else if (++n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: src %0d beat 0x%0h not accepted within 200 cycles", src, d);
        done = 1'b1;
      end
    end
  endtask

  task automatic send_pkt(input int src, input logic [7:0] d[$]);
    for (int i = 0; i < d.size(); i++)
      send_beat(src, d[i], (i == d.size() - 1));
    if (src == 0) begin
      s0_if.tvalid = 1'b0; s0_if.tlast = 1'b0;
    end else begin
      s1_if.tvalid = 1'b0; s1_if.tlast = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    repeat (5) sync();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s0_if.tvalid = 1'b0; s1_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    sync();
    rst_n = 1'b1;
    exp_q.delete();
    mdl_ptr = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0;
    s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0;
    m_if.tready  = 1'b1;

    // 1: reset two cycles, then quiet
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_after_reset",
            32'({m_if.tvalid, select, busy, s0_if.tready, s1_if.tready}), 32'd0);
    end

    // 2: s1 alone, 3 beats
    sync();
    qa = '{8'hA1, 8'hA2, 8'hA3};
    mdl_solo(1, qa);
    fork
      send_pkt(1, qa);
      begin
        @(negedge clk);
        check("t2_pre_grant", 32'({select, s1_if.tready}), 32'd0);
        @(posedge clk); #1;
        check("t2_grant", 32'({select, busy}), 32'({2'b01, 1'b1}));
        @(posedge clk); #1;
        check("t2_beat0", 32'({m_if.tvalid, m_if.tlast, m_if.tdata}), 32'({2'b10, 8'hA1}));
        @(posedge clk); #1;
        check("t2_beat1", 32'({m_if.tvalid, m_if.tlast, m_if.tdata}), 32'({2'b10, 8'hA2}));
        @(posedge clk); #1;
        check("t2_beat2", 32'({m_if.tvalid, m_if.tlast, m_if.tdata, busy}), 32'({2'b11, 8'hA3, 1'b0}));
      end
    join
    drain("t2_drained");

    // 3: contention from reset, s0 first
    do_reset();
    qa = '{8'h10, 8'h11};
    qb = '{8'h20, 8'h21};
    mdl_both(qa, qb);
    fork
      send_pkt(0, qa);
      send_pkt(1, qb);
      begin
        repeat (2) @(posedge clk);
        #1 check("t3_first", 32'({select, m_if.tdata}), 32'({2'b00, 8'h10}));
      end
    join
    drain("t3_round1_drained");

    // lone s0 packet hands priority to s1 for the next tie
    qa = '{8'h18};
    mdl_solo(0, qa);
    send_pkt(0, qa);
    drain("t3_solo_drained");

    qa = '{8'h12, 8'h13};
    qb = '{8'h22, 8'h23};
    mdl_both(qa, qb);
    fork
      send_pkt(0, qa);
      send_pkt(1, qb);
      begin
        repeat (2) @(posedge clk);
        #1 check("t3_round2_first", 32'({select, m_if.tdata}), 32'({2'b01, 8'h22}));
      end
    join
    drain("t3_round2_drained");

    // 4: backpressure at beat 0x31 for 3 cycles
    qa = '{8'h30, 8'h31, 8'h32, 8'h33};
    mdl_solo(0, qa);
    fork
      send_pkt(0, qa);
      begin
        repeat (3) @(posedge clk);
        #1 m_if.tready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("t4_stall", 32'({m_if.tvalid, m_if.tdata, s0_if.tready}), 32'({1'b1, 8'h31, 1'b0}));
        end
        @(posedge clk);
        #1 m_if.tready = 1'b1;
      end
    join
    drain("t4_drained");

    // 5: grant lock while s1 requests mid-packet
    qa = '{8'h60, 8'h61, 8'h62, 8'h63};
    qb = '{8'h70, 8'h71};
    mdl_solo(0, qa);
    mdl_solo(1, qb);
    fork
      send_pkt(0, qa);
      begin
        repeat (2) @(posedge clk);
        #1 send_pkt(1, qb);
      end
      begin
        @(posedge clk);
        repeat (4) begin
          @(negedge clk);
          check("t5_lock", 32'({select, s1_if.tready}), 32'd0);
          @(posedge clk);
        end
      end
    join
    drain("t5_drained");

    // single-beat packet returns to IDLE immediately
    qa = '{8'h44};
    mdl_solo(0, qa);
    send_pkt(0, qa);
    check("single_beat", 32'({busy, m_if.tvalid, m_if.tlast, m_if.tdata}), 32'({3'b011, 8'h44}));
    drain("single_drained");

    // 6: reset after beat 2 of 4, priority was with s1 before the reset
    qa = '{8'h40, 8'h41, 8'h42, 8'h43};
    mdl_solo(0, qa);
    send_beat(0, 8'h40, 1'b0);
    send_beat(0, 8'h41, 1'b0);
    s0_if.tvalid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    mdl_ptr = 1'b0;
    sync();
    rst_n = 1'b1;
    check("t6_after_reset", 32'({m_if.tvalid, busy, select, s0_if.tready}), 32'd0);
    qa = '{8'h50, 8'h51, 8'h52};
    qb = '{8'h58};
    mdl_both(qa, qb);
    fork
      send_pkt(0, qa);
      send_pkt(1, qb);
      begin
        repeat (2) @(posedge clk);
        #1 check("t6_first_after_reset", 32'({select, m_if.tdata}), 32'({2'b00, 8'h50}));
      end
    join
    drain("t6_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
